// File: rtl/instruction_execute_pkg.sv
// Shared decode definitions: opcode values, decoded-word field positions and the
// execute-stage FSM encoding. The decoder stage imports the same constants.
package instruction_execute_pkg;

  localparam int FIELD_W = 4;
  localparam int IMM_W   = 16;
  localparam int OPC_LSB = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 0;

  localparam logic [FIELD_W-1:0] OP_NOP  = 4'h0;
  localparam logic [FIELD_W-1:0] OP_ADD  = 4'h1;
  localparam logic [FIELD_W-1:0] OP_SUB  = 4'h2;
  localparam logic [FIELD_W-1:0] OP_AND  = 4'h3;
  localparam logic [FIELD_W-1:0] OP_OR   = 4'h4;
  localparam logic [FIELD_W-1:0] OP_XOR  = 4'h5;
  localparam logic [FIELD_W-1:0] OP_SHL  = 4'h6;
  localparam logic [FIELD_W-1:0] OP_SHR  = 4'h7;
  localparam logic [FIELD_W-1:0] OP_ADDI = 4'h8;
  localparam logic [FIELD_W-1:0] OP_LUI  = 4'h9;
  localparam logic [FIELD_W-1:0] OP_SLT  = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/instruction_execute_exec_alu.sv
// Combinational ALU for the execute stage, zero latency, no flow control.
// Opcodes B-F flag illegal and return zero.
module instruction_execute_exec_alu
  import instruction_execute_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [FIELD_W-1:0] opcode,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [IMM_W-1:0]   imm,
  output logic [DATA_W-1:0]  result,
  output logic               illegal
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] imm_sx;
  logic [DATA_W-1:0] imm_zx;
  logic [SH_W-1:0]   shamt;

  assign imm_sx = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zx = {{(DATA_W-IMM_W){1'b0}}, imm};
  assign shamt  = b[SH_W-1:0];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (opcode)
      OP_NOP:  result = '0;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      OP_ADDI: result = a + imm_sx;
      OP_LUI:  result = imm_zx << 16;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_execute.sv
// Execute stage: regfile read, ALU, writeback; DOR two cycles after DIR is sampled.
// Holds result with DOR high until ack_to_execute; DIR ignored outside IDLE.
module instruction_execute
  import instruction_execute_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              DOR,
  input  logic              DIR,
  input  logic              ack_to_execute,
  output logic              ack_from_execute,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              exec_err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              exec_err_q, exec_err_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];

  logic [FIELD_W-1:0] opcode, rd, rs1, rs2;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  rs1_val, rs2_val, alu_result;
  logic               alu_illegal, wr_en;

  assign opcode = instr_q[OPC_LSB +: FIELD_W];
  assign rd     = instr_q[RD_LSB  +: FIELD_W];
  assign rs1    = instr_q[RS1_LSB +: FIELD_W];
  assign rs2    = instr_q[RS2_LSB +: FIELD_W];
  assign imm    = instr_q[IMM_LSB +: IMM_W];

  // r0 reads as zero regardless of array contents
  assign rs1_val = (rs1 == '0) ? '0 : regs_q[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : regs_q[rs2];

  instruction_execute_exec_alu #(.DATA_W(DATA_W)) u_exec_alu (
    .opcode  (opcode),
    .a       (rs1_val),
    .b       (rs2_val),
    .imm     (imm),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  assign wr_en = !alu_illegal && (opcode != OP_NOP) && (rd != '0);

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    data_out_d = data_out_q;
    exec_err_d = exec_err_q;
    ack_d      = 1'b0;
    regs_d     = regs_q;
    case (state_q)
      IDLE: begin
        if (DIR) begin
          instr_d = data_in;
          ack_d   = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_out_d = alu_illegal ? '0 : alu_result;
        exec_err_d = alu_illegal;
        if (wr_en) regs_d[rd] = alu_result;
        state_d = OUT;
      end
      OUT: begin
        if (ack_to_execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      data_out_q <= '0;
      exec_err_q <= 1'b0;
      ack_q      <= 1'b0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      data_out_q <= data_out_d;
      exec_err_q <= exec_err_d;
      ack_q      <= ack_d;
      regs_q     <= regs_d;
    end
  end

  assign DOR              = (state_q == OUT);
  assign ack_from_execute = ack_q;
  assign data_out         = data_out_q;
  assign exec_err         = exec_err_q;

endmodule

// File: tb/tb_instruction_execute.sv
// Directed bench for instruction_execute with an architectural model and a per-cycle monitor.
module tb_instruction_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic        DOR;
  logic        DIR;
  logic        ack_to_execute;
  logic        ack_from_execute;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        exec_err;

  instruction_execute #(.DATA_W(32), .REG_COUNT(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .DOR              (DOR),
    .DIR              (DIR),
    .ack_to_execute   (ack_to_execute),
    .ack_from_execute (ack_from_execute),
    .data_in          (data_in),
    .data_out         (data_out),
    .exec_err         (exec_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [16];
  logic        mon_en  = 1'b0;
  logic        exp_dor = 1'b0;
  logic        exp_ack = 1'b0;
  logic [31:0] exp_data = '0;
  logic        exp_err  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  // Architectural model: result of one instruction and its effect on the register file.
  task automatic model(input logic [31:0] w, output logic [31:0] res, output logic err);
    logic [3:0]  op, rd;
    logic [31:0] a, b, sx;
    op  = w[31:28];
    rd  = w[27:24];
    a   = m_regs[w[23:20]];
    b   = m_regs[w[19:16]];
    sx  = {{16{w[15]}}, w[15:0]};
    err = 1'b0;
    case (op)
      4'h0: res = 0;
      4'h1: res = a + b;
      4'h2: res = a - b;
      4'h3: res = a & b;
      4'h4: res = a | b;
      4'h5: res = a ^ b;
      4'h6: res = a << b[4:0];
      4'h7: res = a >> b[4:0];
      4'h8: res = a + sx;
      4'h9: res = {w[15:0], 16'h0000};
      4'hA: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin res = 0; err = 1'b1; end
    endcase
    if (!err && op != 4'h0 && rd != 4'h0) m_regs[rd] = res;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("DOR", {31'b0, DOR}, {31'b0, exp_dor});
      chk("ack_from_execute", {31'b0, ack_from_execute}, {31'b0, exp_ack});
      if (exp_dor) begin
        chk("data_out", data_out, exp_data);
        chk("exec_err", {31'b0, exec_err}, {31'b0, exp_err});
      end
    end
  end

  // Issue one instruction, pin the model with a literal, hold OUT for 'hold' extra cycles.
  task automatic run(input logic [31:0] w, input logic [31:0] lit, input bit lit_err,
                     input int hold, input bit keep_dir, input logic [31:0] next_w);
    logic [31:0] res;
    logic        err;
    model(w, res, err);
    DIR     = 1'b1;
    data_in = w;
    @(posedge clk); #1;
    exp_ack = 1'b1;
    exp_dor = 1'b0;
    DIR     = 1'b0;
    @(posedge clk); #1;
    exp_ack  = 1'b0;
    exp_dor  = 1'b1;
    exp_data = res;
    exp_err  = err;
    chk("literal_result", data_out, lit);
    chk("literal_err", {31'b0, exec_err}, {31'b0, lit_err});
    if (keep_dir) begin
      DIR     = 1'b1;
      data_in = next_w;
    end
    repeat (hold) begin @(posedge clk); #1; end
    ack_to_execute = 1'b1;
    @(posedge clk); #1;
    ack_to_execute = 1'b0;
    exp_dor = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] nxt;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    reset = 1'b1; DIR = 1'b0; ack_to_execute = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_DOR", {31'b0, DOR}, 32'd0);
    chk("reset_ack", {31'b0, ack_from_execute}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_exec_err", {31'b0, exec_err}, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    run(enc(4'h8, 4'd1, 4'd0, 4'd0, 16'h7FFF), 32'h0000_7FFF, 0, 0, 0, 0);
    run(enc(4'h1, 4'd2, 4'd1, 4'd1, 16'h0),    32'h0000_FFFE, 0, 0, 0, 0);
    run(enc(4'h8, 4'd3, 4'd0, 4'd0, 16'hFFFF), 32'hFFFF_FFFF, 0, 0, 0, 0);
    run(enc(4'h2, 4'd4, 4'd0, 4'd3, 16'h0),    32'h0000_0001, 0, 0, 0, 0);
    run(enc(4'hA, 4'd5, 4'd3, 4'd0, 16'h0),    32'h0000_0001, 0, 0, 0, 0);
    run(enc(4'h9, 4'd6, 4'd0, 4'd0, 16'h8000), 32'h8000_0000, 0, 0, 0, 0);
    run(enc(4'h7, 4'd7, 4'd6, 4'd1, 16'h0),    32'h0000_0001, 0, 0, 0, 0);
    run(enc(4'h6, 4'd12, 4'd6, 4'd0, 16'h0),   32'h8000_0000, 0, 0, 0, 0);
    run(enc(4'h8, 4'd0, 4'd0, 4'd0, 16'h0005), 32'h0000_0005, 0, 0, 0, 0);
    run(enc(4'h1, 4'd8, 4'd0, 4'd0, 16'h0),    32'h0000_0000, 0, 0, 0, 0);
    run(enc(4'hC, 4'd2, 4'd1, 4'd1, 16'h1234), 32'h0000_0000, 1, 0, 0, 0);
    run(enc(4'h1, 4'd13, 4'd2, 4'd0, 16'h0),   32'h0000_FFFE, 0, 0, 0, 0);
    run(enc(4'h3, 4'd9, 4'd2, 4'd1, 16'h0),    32'h0000_7FFE, 0, 0, 0, 0);
    run(enc(4'h4, 4'd10, 4'd2, 4'd1, 16'h0),   32'h0000_FFFF, 0, 0, 0, 0);
    run(enc(4'h5, 4'd11, 4'd2, 4'd1, 16'h0),   32'h0000_8001, 0, 0, 0, 0);
    run(enc(4'h0, 4'd1, 4'd2, 4'd2, 16'h0),    32'h0000_0000, 0, 0, 0, 0);
    run(enc(4'h1, 4'd14, 4'd1, 4'd0, 16'h0),   32'h0000_7FFF, 0, 0, 0, 0);
    run(enc(4'hA, 4'd14, 4'd0, 4'd3, 16'h0),   32'h0000_0000, 0, 0, 0, 0);
    run(enc(4'h2, 4'd15, 4'd0, 4'd1, 16'h0),   32'hFFFF_8001, 0, 0, 0, 0);

    // ack_to_execute while idle must not produce DOR or acks
    ack_to_execute = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    ack_to_execute = 1'b0;

    // Backpressure with the next word already offered on DIR
    nxt = enc(4'h8, 4'd9, 4'd9, 4'd0, 16'h0003);
    run(enc(4'h6, 4'd15, 4'd1, 4'd4, 16'h0), 32'h0000_FFFE, 0, 10, 1, nxt);
    run(nxt, 32'h0000_8001, 0, 0, 0, 0);

    // Reset while the next instruction is in EXEC: no writeback, outputs cleared
    DIR     = 1'b1;
    data_in = enc(4'h8, 4'd1, 4'd1, 4'd0, 16'h0100);
    @(posedge clk); #1;
    exp_ack = 1'b1;
    DIR     = 1'b0;
    @(negedge clk);
    mon_en  = 1'b0;
    reset   = 1'b1;
    #1;
    chk("midexec_reset_DOR", {31'b0, DOR}, 32'd0);
    chk("midexec_reset_ack", {31'b0, ack_from_execute}, 32'd0);
    chk("midexec_reset_data_out", data_out, 32'd0);
    exp_ack = 1'b0;
    exp_dor = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    run(enc(4'h1, 4'd15, 4'd1, 4'd2, 16'h0),   32'h0000_0000, 0, 0, 0, 0);
    run(enc(4'h4, 4'd14, 4'd6, 4'd3, 16'h0),   32'h0000_0000, 0, 0, 0, 0);
    run(enc(4'h8, 4'd1, 4'd1, 4'd0, 16'h0000), 32'h0000_0000, 0, 1, 0, 0);

    repeat (2) begin @(posedge clk); #1; end
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
